// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: RGB565 field layout,
// default frame geometry, FSM state encoding and the gray conversion helper.
package cam_pkg;

  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2
  } cam_state_e;

  // Y = R5*8 + G6*4 + B5*2, saturated to 8 bits (maximum raw sum is 562)
  function automatic logic [7:0] rgb565_to_gray(input logic [15:0] px);
    logic [9:0] sum;
    sum = {2'b00, px[R_LSB +: R_W], 3'b000}
        + {2'b00, px[G_LSB +: G_W], 2'b00}
        + {4'b0000, px[B_LSB +: B_W], 1'b0};
    return (sum > 10'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Pairs camera bytes into 16-bit pixel words (high byte first).
// With CAM_GRAY_EN defined the word becomes {8'h00, Y} instead of RGB565.
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [15:0] word
);

  logic       phase_r;
  logic [7:0] hi_r;
  logic [15:0] rgb_s;

  // Byte phase toggles on every valid byte; any gap discards a half word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      hi_r    <= 8'h00;
    end else if (valid) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        hi_r <= data;
      end else begin
        hi_r <= hi_r;
      end
    end else begin
      phase_r <= 1'b0;
      hi_r    <= hi_r;
    end
  end

  assign rgb_s      = {hi_r, data};
  assign word_valid = valid & phase_r;

`ifdef CAM_GRAY_EN
  assign word = {8'h00, rgb565_to_gray(rgb_s)};
`else
  assign word = rgb_s;
`endif

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera parallel-bus capture into the async pixel FIFO write side.
// Optional gray output selected by the CAM_GRAY_EN macro (see cam_byte_packer).
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow
);

  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

  logic              vsync_r;
  logic              vsync_d_r;
  logic              href_r;
  logic              href_d_r;
  logic [7:0]        data_r;
  cam_state_e        state_r;
  logic [SKIP_W-1:0] skip_cnt_r;
  logic [PIX_W-1:0]  pix_cnt_r;
  logic [LINE_W-1:0] line_cnt_r;

  logic              vsync_rise_s;
  logic              vsync_fall_s;
  logic              href_rise_s;
  logic              href_fall_s;
  logic              pack_valid_s;
  logic              word_valid_s;
  logic              line_ok_s;
  logic              pix_ok_s;
  logic [15:0]       word_s;

  // Single input register stage for the camera bus plus edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r   <= 1'b0;
      vsync_d_r <= 1'b0;
      href_r    <= 1'b0;
      href_d_r  <= 1'b0;
      data_r    <= 8'h00;
    end else begin
      vsync_r   <= cam_vsync;
      vsync_d_r <= vsync_r;
      href_r    <= cam_href;
      href_d_r  <= href_r;
      data_r    <= cam_data;
    end
  end

  assign vsync_rise_s = vsync_r & ~vsync_d_r;
  assign vsync_fall_s = ~vsync_r & vsync_d_r;
  assign href_rise_s  = href_r & ~href_d_r;
  assign href_fall_s  = ~href_r & href_d_r;
  assign line_ok_s    = (line_cnt_r < LINE_W'(V_ACTIVE));
  assign pix_ok_s     = (pix_cnt_r < PIX_W'(H_ACTIVE));
  // A vsync rise mid-line ends the frame, so its byte never completes a word
  assign pack_valid_s = (state_r == CAPTURE) & href_r & ~vsync_rise_s;

  cam_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (pack_valid_s),
    .data       (data_r),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Frame FSM, pixel/line geometry counters and registered FIFO-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SKIP;
      skip_cnt_r  <= '0;
      pix_cnt_r   <= '0;
      line_cnt_r  <= '0;
      wr_en       <= 1'b0;
      dout        <= 16'h0000;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state_r)
        SKIP: begin
          if (skip_cnt_r >= SKIP_W'(SKIP_FRAMES)) begin
            state_r <= IDLE;
          end else if (vsync_rise_s) begin
            skip_cnt_r <= skip_cnt_r + SKIP_W'(1);
          end
        end
        IDLE: begin
          if (vsync_fall_s && capture_en) begin
            state_r    <= CAPTURE;
            pix_cnt_r  <= '0;
            line_cnt_r <= '0;
          end
        end
        CAPTURE: begin
          if (vsync_rise_s) begin
            frame_done <= 1'b1;
            state_r    <= IDLE;
          end else begin
            if (href_rise_s && line_ok_s && (line_cnt_r == '0)) begin
              frame_start <= 1'b1;
            end
            // Dropped pixels still advance the count so geometry stays fixed
            if (word_valid_s) begin
              if (pix_ok_s && line_ok_s) begin
                if (!full_fifo) begin
                  wr_en <= 1'b1;
                  dout  <= word_s;
                end else begin
                  overflow <= 1'b1;
                end
              end
              if (pix_ok_s) begin
                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
              end
            end
            if (href_fall_s) begin
              pix_cnt_r <= '0;
              if (line_ok_s) begin
                line_cnt_r <= line_cnt_r + LINE_W'(1);
              end
            end
          end
        end
        default: begin
          state_r <= SKIP;
        end
      endcase
    end
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream producer for the VGA display path.
- Samples the camera's 8-bit parallel bus (vsync/href framing, two bytes per pixel) in the pixel-clock domain.
- Assembles RGB565 words and pushes them into the write side of the async pixel FIFO.
- The display side drains that FIFO at 25 MHz; this block only enforces frame alignment, pixel/line counts and overflow bookkeeping.

Parameters:
- H_ACTIVE, 640, pixels written per line; excess bytes on a line are discarded.
- V_ACTIVE, 480, lines written per frame; excess lines are discarded.
- SKIP_FRAMES, 2, whole frames ignored after reset, while camera registers settle.

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- cam_vsync  in  1  frame sync; high = vertical blanking
- cam_href  in  1  line valid; high = data bytes valid
- cam_data  in  8  camera data byte
- capture_en  in  1  enables capture; sampled only at frame boundaries
- full_fifo  in  1  async FIFO write-side full flag
- wr_en  out  1  FIFO write strobe, one cycle per pixel
- dout  out  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}
- frame_start  out  1  one-cycle pulse when the first line of a captured frame begins
- frame_done  out  1  one-cycle pulse at the end of a captured frame
- overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full

Behaviour:
- Reset values: wr_en=0, dout=0, frame_start=0, frame_done=0, overflow=0. State=SKIP, skip counter=0, byte phase=0, counters=0.
- Inputs cam_vsync, cam_href and cam_data are registered once; all decisions use the registered copies.
- vsync_rise and vsync_fall are derived from the registered vsync and its previous value.
- States:
  - SKIP: count vsync_rise events. When the count reaches SKIP_FRAMES, go to IDLE.
  - IDLE: on vsync_fall with capture_en=1, go to CAPTURE. Clear the pixel counter, line counter and byte phase.
  - CAPTURE: on vsync_rise, pulse frame_done and go to IDLE.
- Line start: in CAPTURE, the first cycle of registered href=1 with line count < V_ACTIVE starts a line. If line count==0, frame_start pulses that cycle.
- Byte assembly (CAPTURE, href=1): phase 0 latches the high byte. Phase 1 forms the word {hi, byte}. Phase toggles every href cycle.
- Pixel write: on phase 1, if pixel count < H_ACTIVE and line count < V_ACTIVE:
  - full_fifo=0: dout=word and wr_en=1 on the next cycle.
  - full_fifo=1: drop the pixel, set overflow.
  - pixel count increments either way (no retry), so geometry stays fixed.
- Latency: second byte on the pins → wr_en high 2 clk later (1 input register + 1 output register).
- Line end: on href falling edge, line count increments (saturating at V_ACTIVE), pixel count and byte phase clear.
  - An odd byte count leaves the half pixel discarded.
- Ignored inputs:
  - href during SKIP/IDLE is ignored.
  - vsync_rise mid-line: frame_done pulses and any half word is discarded.
- capture_en deassert mid-frame: the current frame completes; no new frame starts.
- overflow: cleared only by reset.
- Reset mid-frame: all outputs drop immediately. After reset, SKIP_FRAMES frames are skipped again.

Optional Feature:
- Macro: CAM_GRAY_EN.
- Defined: the pixel word is replaced with {8'h00, Y}, where Y = (R5*8 + G6*4 + B5*2) truncated and saturated to 8 bits, with R5/G6/B5 taken from the assembled RGB565 word.
  - Y is computed combinationally before the output register, so latency is unchanged.
  - This suits the downstream threshold comparison (din>threshold).
- Undefined: raw RGB565 passthrough.

Decomposition:
- Shared package cam_pkg holds:
  - RGB565 field positions and widths;
  - default H_ACTIVE/V_ACTIVE (shared with the VGA side);
  - the state encoding constants (SKIP, IDLE, CAPTURE).
- One natural sub-module, cam_byte_packer: byte phase plus word assembly plus the optional gray conversion. The FSM and counters stay in the top.

Test Plan:
- Reset, SKIP_FRAMES=2, 3 frames of 4 lines × 8 pixels (H_ACTIVE=8, V_ACTIVE=4) → no wr_en in frames 1–2; frame 3 gives 32 wr_en pulses, one frame_start, one frame_done.
- Byte pair 0xF8,0x1F → dout=16'hF81F, wr_en high exactly 2 clk after the second byte.
- Line of 10 pixels with H_ACTIVE=8 → 8 writes; pixels 9–10 dropped; overflow stays 0.
- full_fifo=1 during pixel 3 of a line → 7 writes, overflow=1 and stays set through later frames until rst_n=0.
- capture_en falls mid-frame → that frame completes with all 32 writes and frame_done; the next frame produces zero writes.
- CAM_GRAY_EN defined, pixel 16'hFFFF → dout=16'h00FF; pixel 16'h0000 → dout=16'h0000.
